// File: rtl/icache_line_fill_pkg.sv
// Shared instruction-cache definitions: line-fill FSM encoding and line geometry.
package icache_line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } fill_state_e;

  localparam int WORD_BYTES = 4;

  // Byte-offset width of a cache line: log2(words per line * bytes per word).
  function automatic int line_off_w(input int num_blocks, input int block_size);
    return $clog2(num_blocks * block_size);
  endfunction

  // Line offset width for the default 4-word line.
  localparam int LINE_OFF_W = line_off_w(4, WORD_BYTES);

endpackage

// File: rtl/icache_line_fill.sv
// Line-fill engine: turns one wide I-cache line request into NUM_BLOCKS
// sequential 32-bit instruction reads on a narrow memory port and returns
// the assembled line with a one-cycle ready pulse.
module icache_line_fill
  import icache_line_fill_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mem_req_valid,
  output logic                    mem_req_ready,
  input  logic [31:0]             mem_req_addr,
  output logic [32*NUM_BLOCKS-1:0] mem_req_rdata,
  output logic                    mem_valid,
  output logic                    mem_instr,
  input  logic                    mem_ready,
  output logic [31:0]             mem_addr,
  input  logic [31:0]             mem_rdata
);

  localparam int OFF_W  = line_off_w(NUM_BLOCKS, BLOCK_SIZE);
  localparam int CW     = $clog2(NUM_BLOCKS);
  localparam int LOW_W  = OFF_W - CW;
  localparam logic [CW-1:0] LAST = CW'(NUM_BLOCKS - 1);

  fill_state_e                  state;
  logic [CW-1:0]                cnt;
  logic [31-OFF_W:0]            base_hi;
  logic [NUM_BLOCKS-1:0][31:0]  line;
  logic [CW-1:0]                cnt_nxt;

  // Offset bits of the request address are intentionally discarded.
  logic unused_off;
  assign unused_off = ^mem_req_addr[OFF_W-1:0];

  assign mem_req_rdata = line;
  // The word index lives in its own field of the address, so stepping it
  // can never carry into the line-address bits.
  assign cnt_nxt       = cnt + CW'(1);

  // Fill FSM: all outputs registered; beats only complete while mem_valid is high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      base_hi       <= '0;
      line          <= '0;
      mem_valid     <= 1'b0;
      mem_instr     <= 1'b0;
      mem_addr      <= '0;
      mem_req_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req_valid) begin
            base_hi   <= mem_req_addr[31:OFF_W];
            cnt       <= '0;
            mem_valid <= 1'b1;
            mem_instr <= 1'b1;
            mem_addr  <= {mem_req_addr[31:OFF_W], {OFF_W{1'b0}}};
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            line[cnt] <= mem_rdata;
            if (!mem_req_valid || cnt == LAST) begin
              // Outstanding beat has completed; either respond or abandon.
              mem_valid <= 1'b0;
              mem_instr <= 1'b0;
              if (mem_req_valid) begin
                mem_req_ready <= 1'b1;
                state         <= RESP;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt      <= cnt_nxt;
              mem_addr <= {base_hi, cnt_nxt, {LOW_W{1'b0}}};
            end
          end
        end
        RESP: begin
          mem_req_ready <= 1'b0;
          state         <= DRAIN;
        end
        DRAIN: begin
          // Wait for the cache to retire its request before accepting another.
          if (!mem_req_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache_line_fill.md
ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

Interface
REQ-001 The block SHALL have parameter NUM_BLOCKS, default 4, the number of 32-bit words per cache line (power of two, >= 2).
REQ-002 The block SHALL have parameter BLOCK_SIZE, default 4, the bytes per word (fixed at 4).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 resetn  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 mem_req_valid  input  1  line-fill request from the instruction cache, held until served or abandoned.
REQ-006 mem_req_ready  output  1  one-cycle pulse: mem_req_rdata holds the complete line.
REQ-007 mem_req_addr  input  32  line address; low log2(NUM_BLOCKS*BLOCK_SIZE) bits ignored.
REQ-008 mem_req_rdata  output  32*NUM_BLOCKS  assembled line; word i at bits [32*i +: 32].
REQ-009 mem_valid  output  1  narrow memory read request.
REQ-010 mem_instr  output  1  high whenever mem_valid is high (instruction fetch).
REQ-011 mem_ready  input  1  narrow memory beat complete; mem_rdata valid this cycle.
REQ-012 mem_addr  output  32  word address of the current beat, 4-byte aligned.
REQ-013 mem_rdata  input  32  read data for the current beat.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, RESP, DRAIN.
REQ-015 IDLE: on mem_req_valid=1, latch line base (mem_req_addr with low offset bits zeroed), clear beat counter, set mem_valid=1, mem_addr=base, go FETCH.
REQ-016 FETCH: mem_valid SHALL stay high and mem_addr stable until mem_ready=1.
REQ-017 FETCH on mem_ready=1: write mem_rdata into word slot [counter]; if counter < NUM_BLOCKS-1, increment, mem_addr += 4, keep mem_valid high (back-to-back beats, no bubble).
REQ-018 FETCH on mem_ready=1 with counter = NUM_BLOCKS-1: drop mem_valid; go RESP if mem_req_valid still high, else IDLE (abandoned fill, no response).
REQ-019 RESP: mem_req_ready=1 for exactly one cycle with the full line stable on mem_req_rdata; go DRAIN.
REQ-020 DRAIN: hold mem_req_ready=0; go IDLE in the first cycle mem_req_valid=0; no new request accepted while in DRAIN.
REQ-021 Abandonment: if mem_req_valid falls mid-FETCH, the outstanding beat SHALL complete (mem_valid never dropped before mem_ready), then mem_valid drops and state returns to IDLE, remaining beats skipped.
REQ-022 The beat counter SHALL be log2(NUM_BLOCKS) bits, never wrap within a fill; line address arithmetic SHALL not carry into bits above the line offset.
REQ-023 Latency with mem_ready tied high: mem_req_valid sampled at edge 0, mem_req_ready high in cycle NUM_BLOCKS+1 (5 for default).
REQ-024 mem_req_rdata SHALL hold its last assembled value outside RESP; it is only guaranteed valid while mem_req_ready=1.
REQ-025 mem_ready while mem_valid=0 SHALL be ignored.

Reset
REQ-026 With resetn=0 at a clock edge: state=IDLE, mem_valid=0, mem_instr=0, mem_req_ready=0, mem_addr=0, counter=0, mem_req_rdata=0.
REQ-027 Reset asserted mid-fill SHALL abort immediately; no response pulse after reset release until a new request.

Structure
REQ-028 FSM state encoding and the line offset width constant SHALL live in a shared cache package used by the cache and this block.
REQ-029 The block SHALL be a single module; no sub-modules.

Verification
REQ-030 Zero-wait fill: request 0x0000_1234, mem_ready=1 with mem_rdata=addr -> mem_addr 0x1230,0x1234,0x1238,0x123C; mem_req_rdata={0x123C,0x1238,0x1234,0x1230}, ready pulse in cycle 5.
REQ-031 Wait-state fill: mem_ready high every third cycle -> mem_addr stable during waits, line assembled correctly, exactly one ready pulse.
REQ-032 Abandon: drop mem_req_valid after beat 1 of fill at 0x2000 -> beat 2 completes, mem_valid drops, no mem_req_ready, IDLE; next request 0x3000 fills correctly.
REQ-033 Back-to-back: cache drops valid one cycle after ready, re-requests 0x4010 next cycle -> DRAIN exits, new fill starts at 0x4010, no stale data.
REQ-034 Reset mid-FETCH at beat 2 -> all outputs zero next cycle, no response pulse afterwards.
REQ-035 Protocol checker: mem_valid never falls while awaiting mem_ready; mem_req_ready never high two consecutive cycles.
